// File: rtl/parking_pkg.sv
// parking_pkg: shared state encoding, slot-type constants, width helpers and plate decoding.
package parking_pkg;
  typedef enum logic [2:0] {IDLE, UP_LOADED, PARK, RETURN, UP_EMPTY, PICKUP, DOWN_LOADED, EXIT} state_e;
  localparam logic SEDAN = 1'b0;
  localparam logic SUV = 1'b1;
  function automatic int fw_of(input int floors);
    return $clog2(floors + 1);
  endfunction
  function automatic int cw_of(input int floors, input int slots);
    return $clog2(floors * slots / 2 + 1);
  endfunction
  // An odd last BCD digit marks an SUV.
  function automatic logic plate_is_suv(input logic [3:0] digit);
    return digit[0];
  endfunction
endpackage

// File: rtl/parking_slot_finder.sv
// parking_slot_finder: lowest free slot of a type on non-leaking floors, and location of a plate.
module parking_slot_finder import parking_pkg::*; #(
  parameter int NUM_FLOORS = 7,
  parameter int SLOTS = 8,
  parameter int PLATE_W = 16,
  localparam int FW = fw_of(NUM_FLOORS),
  localparam int SW = $clog2(SLOTS)
) (
  input  logic [NUM_FLOORS*SLOTS*PLATE_W-1:0] parked_i,
  input  logic [NUM_FLOORS:0]                 leak_i,
  input  logic [PLATE_W-1:0]                  plate_i,
  input  logic                                suv_i,
  output logic                                free_found_o,
  output logic [FW-1:0]                       free_floor_o,
  output logic [SW-1:0]                       free_slot_o,
  output logic                                hit_found_o,
  output logic [FW-1:0]                       hit_floor_o,
  output logic [SW-1:0]                       hit_slot_o
);
  // Scanning downwards lets the last match win, i.e. the lowest floor and slot.
  always_comb begin
    free_found_o = 1'b0;
    free_floor_o = '0;
    free_slot_o = '0;
    hit_found_o = 1'b0;
    hit_floor_o = '0;
    hit_slot_o = '0;
    for (int f = NUM_FLOORS; f >= 1; f--)
      for (int s = SLOTS - 1; s >= 0; s--) begin
        if (!leak_i[f] && ((s >= SLOTS / 2) ? SUV : SEDAN) == suv_i &&
            parked_i[((f - 1) * SLOTS + s) * PLATE_W +: PLATE_W] == '0) begin
          free_found_o = 1'b1;
          free_floor_o = FW'(f);
          free_slot_o = SW'(s);
        end
        if (plate_i != '0 && parked_i[((f - 1) * SLOTS + s) * PLATE_W +: PLATE_W] == plate_i) begin
          hit_found_o = 1'b1;
          hit_floor_o = FW'(f);
          hit_slot_o = SW'(s);
        end
      end
  end
endmodule

// File: rtl/parking_lot_ctrl_param.sv
// parking_lot_ctrl_param: slot storage, single-elevator trip FSM, fee computation and leak-aware allocation.
module parking_lot_ctrl_param import parking_pkg::*; #(
  parameter int NUM_FLOORS = 7,
  parameter int SLOTS = 8,
  parameter int PLATE_W = 16,
  parameter int FEE_RATE = 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [PLATE_W-1:0]                  license_plate,
  input  logic                                in_mode,
  input  logic                                out_mode,
  input  logic                                leakage,
  input  logic [fw_of(NUM_FLOORS)-1:0]        leakage_floor,
  output logic [NUM_FLOORS*SLOTS*PLATE_W-1:0] parked,
  output logic [fw_of(NUM_FLOORS)-1:0]        current_floor,
  output logic [PLATE_W-1:0]                  moving,
  output logic                                plate_type,
  output logic [7:0]                          fee,
  output logic                                fee_valid,
  output logic [cw_of(NUM_FLOORS, SLOTS)-1:0] empty_suv,
  output logic [cw_of(NUM_FLOORS, SLOTS)-1:0] empty_sedan,
  output logic                                full_suv,
  output logic                                full_sedan,
  output logic                                busy,
  output logic                                reject
);
  localparam int FW = fw_of(NUM_FLOORS);
  localparam int CW = cw_of(NUM_FLOORS, SLOTS);
  localparam int SW = $clog2(SLOTS);
  localparam int N = NUM_FLOORS * SLOTS;
  localparam int IW = $clog2(N);
  state_e state_q, state_d;
  logic [FW-1:0] floor_q, floor_d, tgt_floor_q, tgt_floor_d, free_floor, hit_floor;
  logic [SW-1:0] tgt_slot_q, tgt_slot_d, free_slot, hit_slot;
  logic [PLATE_W-1:0] moving_q, moving_d;
  logic [PLATE_W-1:0] slots_q [N];
  logic [15:0] ts_q [N];
  logic [15:0] counter_q, age;
  logic [31:0] cost;
  logic [7:0] fee_q, fee_d;
  logic fee_valid_q, fee_valid_d, reject_q, reject_d;
  logic free_found, hit_found, park_ok, get_ok;
  logic [NUM_FLOORS:0] leak;
  logic [IW-1:0] tidx;
  logic [CW-1:0] es, ed;
  for (genvar i = 0; i < N; i++) begin : g_flat
    assign parked[i*PLATE_W +: PLATE_W] = slots_q[i];
  end
  always_comb begin
    leak = '0;
    for (int f = 1; f <= NUM_FLOORS; f++) leak[f] = leakage && (int'(leakage_floor) == f);
  end
  parking_slot_finder #(.NUM_FLOORS(NUM_FLOORS), .SLOTS(SLOTS), .PLATE_W(PLATE_W)) u_finder (
    .parked_i(parked), .leak_i(leak), .plate_i(license_plate), .suv_i(plate_is_suv(license_plate[3:0])),
    .free_found_o(free_found), .free_floor_o(free_floor), .free_slot_o(free_slot),
    .hit_found_o(hit_found), .hit_floor_o(hit_floor), .hit_slot_o(hit_slot)
  );
  assign park_ok = in_mode && !out_mode && license_plate != '0 && !hit_found && free_found;
  assign get_ok = out_mode && !in_mode && hit_found && !leak[hit_floor];
  assign tidx = IW'(int'(tgt_floor_q) * SLOTS + int'(tgt_slot_q) - SLOTS);
  assign age = counter_q - ts_q[tidx];
  assign cost = 32'(age) * 32'(FEE_RATE);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        state_d = park_ok ? UP_LOADED : get_ok ? UP_EMPTY : IDLE;
      UP_LOADED:   state_d = (floor_q + 1'b1 == tgt_floor_q) ? PARK : UP_LOADED;
      PARK:        state_d = RETURN;
      RETURN:      state_d = (floor_q == FW'(1)) ? IDLE : RETURN;
      UP_EMPTY:    state_d = (floor_q + 1'b1 == tgt_floor_q) ? PICKUP : UP_EMPTY;
      PICKUP:      state_d = DOWN_LOADED;
      DOWN_LOADED: state_d = (floor_q == FW'(1)) ? EXIT : DOWN_LOADED;
      EXIT:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end
  always_comb begin
    floor_d = floor_q;
    moving_d = moving_q;
    fee_d = fee_q;
    fee_valid_d = 1'b0;
    reject_d = 1'b0;
    tgt_floor_d = tgt_floor_q;
    tgt_slot_d = tgt_slot_q;
    case (state_q)
      IDLE: begin
        reject_d = (in_mode || out_mode) && !park_ok && !get_ok;
        moving_d = park_ok ? license_plate : '0;
        tgt_floor_d = park_ok ? free_floor : get_ok ? hit_floor : tgt_floor_q;
        tgt_slot_d = park_ok ? free_slot : get_ok ? hit_slot : tgt_slot_q;
      end
      UP_LOADED, UP_EMPTY:  floor_d = floor_q + 1'b1;
      RETURN, DOWN_LOADED:  floor_d = floor_q - 1'b1;
      PARK:                 moving_d = '0;
      PICKUP: begin
        moving_d = slots_q[tidx];
        fee_d = (cost > 32'd255) ? 8'hff : cost[7:0];
      end
      EXIT: begin
        moving_d = '0;
        fee_valid_d = 1'b1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      floor_q <= '0;
      tgt_floor_q <= '0;
      tgt_slot_q <= '0;
      moving_q <= '0;
      fee_q <= '0;
      fee_valid_q <= 1'b0;
      reject_q <= 1'b0;
      counter_q <= '0;
      for (int i = 0; i < N; i++) begin
        slots_q[i] <= '0;
        ts_q[i] <= '0;
      end
    end else begin
      floor_q <= floor_d;
      tgt_floor_q <= tgt_floor_d;
      tgt_slot_q <= tgt_slot_d;
      moving_q <= moving_d;
      fee_q <= fee_d;
      fee_valid_q <= fee_valid_d;
      reject_q <= reject_d;
      counter_q <= counter_q + 16'd1;
      if (state_q == PARK) begin
        slots_q[tidx] <= moving_q;
        ts_q[tidx] <= counter_q;
      end
      if (state_q == PICKUP) slots_q[tidx] <= '0;
    end
  end
  always_comb begin
    es = '0;
    ed = '0;
    for (int f = 1; f <= NUM_FLOORS; f++)
      for (int s = 0; s < SLOTS; s++)
        if (!leak[f] && slots_q[(f - 1) * SLOTS + s] == '0) begin
          if (s >= SLOTS / 2) es = es + CW'(1);
          else ed = ed + CW'(1);
        end
  end
  assign empty_suv = es;
  assign empty_sedan = ed;
  assign full_suv = es == '0;
  assign full_sedan = ed == '0;
  assign current_floor = floor_q;
  assign moving = moving_q;
  assign plate_type = moving_q != '0 && plate_is_suv(moving_q[3:0]);
  assign fee = fee_q;
  assign fee_valid = fee_valid_q;
  assign reject = reject_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_parking_lot_ctrl_param.sv
// tb_parking_lot_ctrl_param: directed scenarios for the parking-lot controller with hand-computed expectations.
module tb_parking_lot_ctrl_param;
  localparam int NF = 7;
  localparam int SL = 8;
  localparam int PW = 16;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [PW-1:0] license_plate = '0;
  logic in_mode = 1'b0;
  logic out_mode = 1'b0;
  logic leakage = 1'b0;
  logic [2:0] leakage_floor = '0;
  logic [NF*SL*PW-1:0] parked;
  logic [2:0] current_floor;
  logic [PW-1:0] moving;
  logic plate_type;
  logic [7:0] fee;
  logic fee_valid;
  logic [4:0] empty_suv, empty_sedan;
  logic full_suv, full_sedan, busy, reject;
  int n_vec = 0;
  int n_err = 0;
  int edges = 0;
  int park_edge = 0;

  parking_lot_ctrl_param #(.NUM_FLOORS(NF), .SLOTS(SL), .PLATE_W(PW), .FEE_RATE(1)) dut (
    .clock(clock), .reset(reset), .license_plate(license_plate), .in_mode(in_mode),
    .out_mode(out_mode), .leakage(leakage), .leakage_floor(leakage_floor), .parked(parked),
    .current_floor(current_floor), .moving(moving), .plate_type(plate_type), .fee(fee),
    .fee_valid(fee_valid), .empty_suv(empty_suv), .empty_sedan(empty_sedan),
    .full_suv(full_suv), .full_sedan(full_sedan), .busy(busy), .reject(reject)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edges++;

  function automatic logic [PW-1:0] slot_at(input int f, input int s);
    return parked[((f - 1) * SL + s) * PW +: PW];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic request(input logic [PW-1:0] p, input logic i, input logic o);
    license_plate = p;
    in_mode = i;
    out_mode = o;
    step();
    in_mode = 1'b0;
    out_mode = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_timeout: busy=%b want 0", tag, busy); end
  endtask

  task automatic test_reset();
    step();
    step();
    n_vec++; if (moving !== 16'h0) begin n_err++; $display("FAIL rst_moving: got %h want 0", moving); end
    n_vec++; if (current_floor !== 3'd0) begin n_err++; $display("FAIL rst_floor: got %0d want 0", current_floor); end
    n_vec++; if ({busy, fee_valid, reject} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {busy, fee_valid, reject}); end
    n_vec++; if (fee !== 8'd0) begin n_err++; $display("FAIL rst_fee: got %0d want 0", fee); end
    n_vec++; if (parked !== '0) begin n_err++; $display("FAIL rst_parked: got nonzero want 0"); end
    n_vec++; if ({empty_suv, empty_sedan} !== {5'd28, 5'd28}) begin n_err++; $display("FAIL rst_counts: got %0d/%0d want 28/28", empty_suv, empty_sedan); end
    n_vec++; if ({full_suv, full_sedan} !== 2'b00) begin n_err++; $display("FAIL rst_full: got %b want 00", {full_suv, full_sedan}); end
    reset = 1'b1;
    step();
    request(16'h5555, 1'b1, 1'b0);
    n_vec++; if (moving !== 16'h5555) begin n_err++; $display("FAIL trip_moving: got %h want 5555", moving); end
    step();
    n_vec++; if (current_floor !== 3'd1) begin n_err++; $display("FAIL trip_floor: got %0d want 1", current_floor); end
    #3 reset = 1'b0;
    #1;
    n_vec++; if (current_floor !== 3'd0) begin n_err++; $display("FAIL async_floor: got %0d want 0", current_floor); end
    n_vec++; if (moving !== 16'h0) begin n_err++; $display("FAIL async_moving: got %h want 0", moving); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_busy: got %b want 0", busy); end
    step();
    reset = 1'b1;
    step();
    step();
    n_vec++; if (parked !== '0) begin n_err++; $display("FAIL discard_parked: got nonzero want 0"); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL discard_busy: got %b want 0", busy); end
  endtask

  task automatic test_park_sedan();
    request(16'h8754, 1'b1, 1'b0);
    n_vec++; if (moving !== 16'h8754) begin n_err++; $display("FAIL sedan_moving: got %h want 8754", moving); end
    n_vec++; if (plate_type !== 1'b0) begin n_err++; $display("FAIL sedan_type: got %b want 0", plate_type); end
    n_vec++; if ({busy, current_floor} !== {1'b1, 3'd0}) begin n_err++; $display("FAIL sedan_k: got busy=%b floor=%0d want 1/0", busy, current_floor); end
    step();
    n_vec++; if (current_floor !== 3'd1) begin n_err++; $display("FAIL sedan_k1_floor: got %0d want 1", current_floor); end
    step();
    park_edge = edges;
    n_vec++; if (slot_at(1, 0) !== 16'h8754) begin n_err++; $display("FAIL sedan_slot: got %h want 8754", slot_at(1, 0)); end
    n_vec++; if (moving !== 16'h0) begin n_err++; $display("FAIL sedan_unload: got %h want 0", moving); end
    step();
    n_vec++; if ({busy, current_floor} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL sedan_k3: got busy=%b floor=%0d want 0/0", busy, current_floor); end
  endtask

  task automatic test_park_suv();
    request(16'h9423, 1'b1, 1'b0);
    n_vec++; if (plate_type !== 1'b1) begin n_err++; $display("FAIL suv_type: got %b want 1", plate_type); end
    license_plate = 16'h7777;
    in_mode = 1'b1;
    step();
    in_mode = 1'b0;
    n_vec++; if (reject !== 1'b0) begin n_err++; $display("FAIL busy_ignore: reject got %b want 0", reject); end
    step();
    n_vec++; if (slot_at(1, 4) !== 16'h9423) begin n_err++; $display("FAIL suv_slot: got %h want 9423", slot_at(1, 4)); end
    step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL suv_idle: busy got %b want 0", busy); end
    n_vec++; if (slot_at(1, 5) !== 16'h0) begin n_err++; $display("FAIL busy_ignore_slot: got %h want 0", slot_at(1, 5)); end
    n_vec++; if ({empty_suv, empty_sedan} !== {5'd27, 5'd27}) begin n_err++; $display("FAIL suv_counts: got %0d/%0d want 27/27", empty_suv, empty_sedan); end
  endtask

  task automatic test_fee();
    while (edges < park_edge + 17) step();
    request(16'h8754, 1'b0, 1'b1);
    n_vec++; if ({busy, moving} !== {1'b1, 16'h0}) begin n_err++; $display("FAIL out_accept: got busy=%b moving=%h want 1/0", busy, moving); end
    step();
    n_vec++; if (current_floor !== 3'd1) begin n_err++; $display("FAIL out_up: got %0d want 1", current_floor); end
    step();
    n_vec++; if (moving !== 16'h8754) begin n_err++; $display("FAIL pickup_moving: got %h want 8754", moving); end
    n_vec++; if (slot_at(1, 0) !== 16'h0) begin n_err++; $display("FAIL pickup_clear: got %h want 0", slot_at(1, 0)); end
    n_vec++; if (fee !== 8'd20) begin n_err++; $display("FAIL pickup_fee: got %0d want 20", fee); end
    n_vec++; if (fee_valid !== 1'b0) begin n_err++; $display("FAIL pickup_valid: got %b want 0", fee_valid); end
    step();
    n_vec++; if ({busy, current_floor} !== {1'b1, 3'd0}) begin n_err++; $display("FAIL down_floor: got busy=%b floor=%0d want 1/0", busy, current_floor); end
    step();
    n_vec++; if ({fee_valid, busy, moving} !== {1'b1, 1'b0, 16'h0}) begin n_err++; $display("FAIL exit: got valid=%b busy=%b moving=%h want 1/0/0", fee_valid, busy, moving); end
    n_vec++; if (empty_sedan !== 5'd28) begin n_err++; $display("FAIL exit_sedan: got %0d want 28", empty_sedan); end
    step();
    n_vec++; if ({fee_valid, fee} !== {1'b0, 8'd20}) begin n_err++; $display("FAIL fee_hold: got valid=%b fee=%0d want 0/20", fee_valid, fee); end
  endtask

  task automatic test_leakage();
    leakage = 1'b1;
    leakage_floor = 3'd1;
    #1;
    n_vec++; if ({empty_suv, empty_sedan} !== {5'd24, 5'd24}) begin n_err++; $display("FAIL leak_counts: got %0d/%0d want 24/24", empty_suv, empty_sedan); end
    request(16'h1111, 1'b1, 1'b0);
    step();
    n_vec++; if (current_floor !== 3'd1) begin n_err++; $display("FAIL leak_k1: got %0d want 1", current_floor); end
    step();
    n_vec++; if (current_floor !== 3'd2) begin n_err++; $display("FAIL leak_k2: got %0d want 2", current_floor); end
    step();
    n_vec++; if (slot_at(2, 4) !== 16'h1111) begin n_err++; $display("FAIL leak_slot: got %h want 1111", slot_at(2, 4)); end
    step();
    n_vec++; if (current_floor !== 3'd1) begin n_err++; $display("FAIL leak_k4: got %0d want 1", current_floor); end
    step();
    n_vec++; if ({busy, current_floor} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL leak_k5: got busy=%b floor=%0d want 0/0", busy, current_floor); end
    n_vec++; if (empty_suv !== 5'd23) begin n_err++; $display("FAIL leak_suv: got %0d want 23", empty_suv); end
    request(16'h9423, 1'b0, 1'b1);
    n_vec++; if ({reject, busy} !== 2'b10) begin n_err++; $display("FAIL leak_out_reject: got reject=%b busy=%b want 1/0", reject, busy); end
    step();
    n_vec++; if (reject !== 1'b0) begin n_err++; $display("FAIL reject_pulse: got %b want 0", reject); end
    n_vec++; if (slot_at(1, 4) !== 16'h9423) begin n_err++; $display("FAIL leak_keep: got %h want 9423", slot_at(1, 4)); end
    leakage_floor = 3'd0;
    #1;
    n_vec++; if ({empty_suv, empty_sedan} !== {5'd26, 5'd28}) begin n_err++; $display("FAIL leak_floor0: got %0d/%0d want 26/28", empty_suv, empty_sedan); end
    leakage = 1'b0;
  endtask

  task automatic test_full_sedan();
    logic [PW-1:0] p;
    for (int i = 0; i < 28; i++) begin
      p = {4'h4, 4'(i / 10), 4'(i % 10), 4'h2};
      request(p, 1'b1, 1'b0);
      wait_idle("fill");
      n_vec++; if (slot_at(1 + i / 4, i % 4) !== p) begin n_err++; $display("FAIL fill_slot%0d: got %h want %h", i, slot_at(1 + i / 4, i % 4), p); end
    end
    n_vec++; if ({full_sedan, empty_sedan} !== {1'b1, 5'd0}) begin n_err++; $display("FAIL full_sedan: got %b/%0d want 1/0", full_sedan, empty_sedan); end
    n_vec++; if ({full_suv, empty_suv} !== {1'b0, 5'd26}) begin n_err++; $display("FAIL full_suv: got %b/%0d want 0/26", full_suv, empty_suv); end
    request(16'h4992, 1'b1, 1'b0);
    n_vec++; if ({reject, busy} !== 2'b10) begin n_err++; $display("FAIL full_reject: got reject=%b busy=%b want 1/0", reject, busy); end
    step();
    request(16'h9423, 1'b1, 1'b1);
    n_vec++; if ({reject, busy} !== 2'b10) begin n_err++; $display("FAIL both_reject: got reject=%b busy=%b want 1/0", reject, busy); end
    step();
    request(16'h1234, 1'b0, 1'b1);
    n_vec++; if ({reject, busy} !== 2'b10) begin n_err++; $display("FAIL unknown_reject: got reject=%b busy=%b want 1/0", reject, busy); end
    step();
    request(16'h9423, 1'b1, 1'b0);
    n_vec++; if ({reject, busy} !== 2'b10) begin n_err++; $display("FAIL dup_reject: got reject=%b busy=%b want 1/0", reject, busy); end
    step();
  endtask

  initial begin
    test_reset();
    test_park_sedan();
    test_park_suv();
    test_fee();
    test_leakage();
    test_full_sedan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/parking_lot_ctrl_param.md
Name: parking_lot_ctrl_param

Overview:
- Parametrised next-generation parking-lot controller: floor count, slots per floor, plate width and fee rate are configurable.
- Owns slot storage, per-slot entry timestamps, the single-elevator FSM (one floor per cycle), fee computation and leakage-aware allocation.
- Sits under the parking-lot top level and drives its display and status outputs.

Parameters:
- NUM_FLOORS, 7, parking floors 1..NUM_FLOORS; floor 0 is the entrance/exit.
- SLOTS, 8, slots per floor (even). Indices 0..SLOTS/2-1 are sedan, SLOTS/2..SLOTS-1 are SUV.
- PLATE_W, 16, plate width (4 BCD digits); 0 means "no car".
- FEE_RATE, 1, fee units per parked cycle.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- license_plate  in  PLATE_W  plate for the request
- in_mode  in  1  park request (sampled in IDLE only)
- out_mode  in  1  retrieve request (sampled in IDLE only)
- leakage  in  1  level: leakage_floor is currently leaking
- leakage_floor  in  FW  leaking floor; FW = clog2(NUM_FLOORS+1)
- parked  out  NUM_FLOORS*SLOTS*PLATE_W  flat slot array; floor f, slot s at offset ((f-1)*SLOTS+s)*PLATE_W
- current_floor  out  FW  elevator position
- moving  out  PLATE_W  plate in the elevator, 0 if empty
- plate_type  out  1  type of moving: 1 = SUV (last digit odd), 0 = sedan; 0 when moving==0
- fee  out  8  fee of the last exited car; holds until the next exit
- fee_valid  out  1  one-cycle pulse on exit
- empty_suv / empty_sedan  out  CW  free slots of each type on non-leaking floors; CW = clog2(NUM_FLOORS*SLOTS/2+1)
- full_suv / full_sedan  out  1  corresponding empty count == 0
- busy  out  1  state != IDLE
- reject  out  1  one-cycle pulse when a request is refused

Behaviour:
- Reset (async, reset==0): all slots 0, timestamps 0, current_floor 0, moving 0, fee 0, fee_valid/reject 0, state IDLE, cycle counter 0. A reset mid-trip discards the carried car.
- cycle counter: free-running, 16 bits, wraps.
- Leaking floor: leakage==1 and 1<=leakage_floor<=NUM_FLOORS. Any other leakage_floor value is ignored.
- Request handling in IDLE:
  - in_mode&out_mode both 1 -> reject.
  - in_mode: reject if the plate is 0, already parked, or no free slot of its type exists on a non-leaking floor. Otherwise target = lowest non-leaking floor with a free slot, then the lowest free slot index of that type on it.
  - out_mode: reject if the plate is not found or its floor is leaking. Otherwise target = that slot.
  - Requests outside IDLE are ignored with no reject.
- States: IDLE, UP_LOADED, PARK, RETURN, UP_EMPTY, PICKUP, DOWN_LOADED, EXIT.
- Park trip (accept at edge k, target floor f):
  - moving<=plate at edge k.
  - UP_LOADED: floor increments 1 per edge; floor==f at edge k+f.
  - PARK at edge k+f+1: slot<=plate, timestamp<=counter, moving<=0.
  - RETURN: floor decrements per edge; reaches 0 and enters IDLE at edge k+2f+1.
- Retrieve trip (accept at edge k, car on floor f):
  - UP_EMPTY reaches f at edge k+f.
  - PICKUP at edge k+f+1: moving<=plate, slot<=0, fee<=min(255, ((counter-timestamp) mod 2^16)*FEE_RATE).
  - DOWN_LOADED reaches floor 0 at edge k+2f+1.
  - EXIT at edge k+2f+2: moving<=0, fee_valid=1, back to IDLE.
- current_floor never changes by more than 1 per cycle.
- Allocation is fixed at accept. Leakage that starts after accept does not abort a trip.
- Counts and full flags are combinational from the slot array and leakage.

Decomposition:
- Package parking_pkg: state enum, SEDAN/SUV constants, FW/CW width functions, plate_is_suv function.
- One sub-module, parking_slot_finder: combinational search returning first free slot/floor by type with leak mask, and plate match location/found.

Test Plan:
- Reset with reset=0 mid-trip at cycle 5 -> all outputs 0 immediately, floor 0, IDLE after release.
- In 8754 (sedan) at edge k -> moving=8754, floor 1 at k+1, floor-1 slot 0 = 8754 at k+2, floor 0 and IDLE at k+3.
- Then in 9423 (SUV) -> floor-1 slot 4; empty_suv=27, empty_sedan=27.
- Out 8754 parked 20 cycles before PICKUP -> fee=20 with fee_valid pulse, slot cleared, empty_sedan=28.
- Leakage on floor 1, in 1111 -> placed floor 2 slot 4; out 9423 -> reject pulse, state stays IDLE.
- Fill all 28 sedan slots -> full_sedan=1; next sedan request and simultaneous in+out -> reject, no state change.
